// File: rtl/board_input_debouncer.sv
// Board input conditioner for the DE1-SoC KEY/SW pins.
// Each channel passes through a two-flop synchronizer and polarity
// normalisation (after normalisation, 1 = pressed/on). A per-channel
// stability counter then accepts a new level only after STABLE_CYCLES
// consecutive samples that differ from the current debounced level.
// A one-cycle rise or fall strobe accompanies each accepted change.
module board_input_debouncer #(
    parameter int               WIDTH         = 14,
    parameter int               STABLE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] INVERT_MASK   = 14'h000F
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] state_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             changed_o
);

    localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] s;
    logic [CNT_W-1:0] cnt [WIDTH];

    // Two-flop synchronizer. Reset loads the inactive pin level, so every
    // normalised sample reads 0 straight out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= INVERT_MASK;
            sync2 <= INVERT_MASK;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
        end
    end

    // Polarity normalisation: active-low pins are flipped here.
    always_comb begin
        s = sync2 ^ INVERT_MASK;
    end

    // Per-channel stability counter, debounced level and edge strobes.
    // Any sample equal to the current level restarts qualification from
    // zero. The counter saturates at CNT_LAST: reaching it on a differing
    // sample accepts the new level instead of incrementing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_o <= '0;
            rise_o  <= '0;
            fall_o  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s[i] == state_o[i]) begin
                    cnt[i]    <= '0;
                    rise_o[i] <= 1'b0;
                    fall_o[i] <= 1'b0;
                end else if (cnt[i] == CNT_LAST) begin
                    state_o[i] <= s[i];
                    cnt[i]     <= '0;
                    rise_o[i]  <= s[i];
                    fall_o[i]  <= ~s[i];
                end else begin
                    cnt[i]    <= cnt[i] + CNT_ONE;
                    rise_o[i] <= 1'b0;
                    fall_o[i] <= 1'b0;
                end
            end
        end
    end

    // Summary strobe. It is built only from the registered strobes, so it
    // stays glitch-free.
    always_comb begin
        changed_o = |(rise_o | fall_o);
    end

endmodule
